// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: wait-stated single-port data memory behind valid/ready request and response handshakes.
// Optional macro DMEM_BOUNDS_CHECK_EN flags and suppresses accesses with addr >= DEPTH (otherwise addresses wrap).
module data_mem_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic          r_we;
    logic [15:0]   r_addr, r_wdata, r_rdata;
    logic          r_err;
    logic [15:0]   r_mem [DEPTH];
    logic          w_accept, w_access, w_we, w_oob;
    logic [15:0]   w_addr, w_wdata;
    logic [AW-1:0] w_idx;
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: if (req_valid) begin
                w_accept = 1'b1;
                if (WAIT_CYCLES == 0) begin
                    w_state_nxt = RESP;
                    w_access    = 1'b1;
                end else begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                end
            end
            WAIT: if (r_cnt == 4'd0) begin
                w_state_nxt = RESP;
                w_access    = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - 4'd1;
            end
            RESP: if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    // with zero wait states the access happens on the acceptance edge, before the latches hold the request
    assign w_we    = w_accept ? req_we    : r_we;
    assign w_addr  = w_accept ? req_addr  : r_addr;
    assign w_wdata = w_accept ? req_wdata : r_wdata;
    assign w_idx   = w_addr[AW-1:0];
`ifdef DMEM_BOUNDS_CHECK_EN
    assign w_oob = int'({16'd0, w_addr}) >= DEPTH;
`else
    assign w_oob = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_access) begin
                r_err   <= w_oob;
                r_rdata <= (w_we || w_oob) ? 16'd0 : r_mem[w_idx];
            end
        end
    end
    always_ff @(posedge clk)
        if (!reset && w_access && w_we && !w_oob) r_mem[w_idx] <= w_wdata;
    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl; accepted requests queue up and a negedge monitor
// checks latency, data, error flag and handshake rules against an associative-array memory model.
module tb_data_mem_ctrl;
    localparam int W     = 2;
    localparam int DEPTH = 1024;
    logic        clk = 0, reset = 1;
    logic        req_valid = 0, req_we = 0, rsp_ready = 1;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );
    always #5 clk = ~clk;
    typedef struct {logic we; logic [15:0] addr; logic [15:0] data; int acc;} txn_t;
    txn_t        pend[$];
    logic [15:0] model [int];
    int          checks = 0, failures = 0, cyc = 0, rdy_mode = 0, last_acc = -1, stream_acc = 0;
    bit          stream_chk = 0, have_exp = 0, exp_known = 0, exp_err = 0, prev_v = 0, prev_cons = 0;
    logic [15:0] exp_rd = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
        else if (rdy_mode == 0) rsp_ready = 1'b1;
    end
    // monitor: expected response is resolved when rsp_valid rises (the commit point of the access)
    initial forever begin
        @(negedge clk);
        if (reset) begin
            pend.delete();
            have_exp  = 0;
            prev_v    = 0;
            prev_cons = 0;
        end else begin
            if (prev_cons) chk("idle_after_consume", {30'd0, req_ready, rsp_valid}, 32'b10);
            if (req_ready && rsp_valid) chk("ready_valid_exclusive", 1, 0);
            if (rsp_valid && !prev_v) begin
                if (pend.size() == 0) chk("spurious_rsp", 1, 0);
                else begin
                    txn_t t;
                    bit oob;
                    int idx;
                    t = pend.pop_front();
                    chk("latency", cyc - t.acc, W + 1);
`ifdef DMEM_BOUNDS_CHECK_EN
                    oob = int'(t.addr) >= DEPTH;
`else
                    oob = 0;
`endif
                    idx       = int'(t.addr) % DEPTH;
                    exp_err   = oob;
                    exp_known = 1;
                    exp_rd    = 0;
                    if (!oob && t.we) model[idx] = t.data;
                    else if (!oob) begin
                        exp_known = model.exists(idx);
                        if (exp_known) exp_rd = model[idx];
                    end
                    have_exp = 1;
                end
            end
            if (rsp_valid && have_exp) begin
                chk("rsp_err", rsp_err, exp_err);
                if (exp_known) chk("rsp_rdata", rsp_rdata, exp_rd);
            end
            prev_v    = rsp_valid;
            prev_cons = rsp_valid && rsp_ready;
            if (prev_cons) have_exp = 0;
            if (req_valid && req_ready) begin
                pend.push_back('{req_we, req_addr, req_wdata, cyc + 1});
                if (stream_chk) begin
                    if (last_acc >= 0) chk("accept_spacing", cyc + 1 - last_acc, W + 3);
                    last_acc = cyc + 1;
                    stream_acc++;
                end
            end
        end
    end
    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d);
        int t;
        req_valid = 1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (t == 100) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 0;
        req_wdata = 16'($urandom);
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        int t;
        logic [15:0] rd0;
        logic        er0;
        idle(3);
        reset = 0;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);
        idle(1);
        issue(1, 16'h0005, 16'hBEEF);
        issue(0, 16'h0005, 16'h0000);
        issue(1, 16'h0003, 16'h0777);
        issue(1, 16'h0403, 16'h00AA);
        issue(0, 16'h0003, 16'h0000);
        issue(1, 16'h0010, 16'h5555);
        idle(6);
        rdy_mode = 2;
        rsp_ready = 0;
        issue(0, 16'h0005, 16'h0000);
        for (t = 0; t < 20 && !rsp_valid; t++) @(negedge clk);
        chk("bp_rsp_seen", rsp_valid, 1);
        chk("bp_rdata_beef", rsp_rdata, 16'hBEEF);
        rd0 = rsp_rdata;
        er0 = rsp_err;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_rdata", rsp_rdata, rd0);
            chk("bp_hold_err", rsp_err, er0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1;
        rdy_mode  = 0;
        idle(3);
        issue(1, 16'h0010, 16'h1234);
        reset = 1;
        idle(1);
        reset = 0;
        repeat (6) begin
            @(negedge clk);
            chk("reset_drop_no_rsp", rsp_valid, 0);
        end
        idle(1);
        issue(0, 16'h0010, 16'h0000);
        idle(6);
        rdy_mode = 1;
        repeat (150) begin
            idle($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15)),
                  16'($urandom));
        end
        rdy_mode = 0;
        idle(8);
        last_acc   = -1;
        stream_chk = 1;
        req_we     = 0;
        req_addr   = 16'h0005;
        req_valid  = 1;
        idle(10 * (W + 3) + 2);
        req_valid  = 0;
        @(negedge clk);
        stream_chk = 0;
        chk("stream_accepts", stream_acc >= 10, 1);
        for (t = 0; t < 200 && pend.size() != 0; t++) @(negedge clk);
        idle(4);
        chk("drain", pend.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
